// File: rtl/smem_store_unit_pkg.sv
// rtl/smem_store_unit_pkg.sv - shared pipeline header for the store unit
//   Bank geometry, read-id width and pipeline status codes.
//   SMEM_DEPTH     : entries per bank
//   SMEM_ADDR_W    : bank address width, clog2(SMEM_DEPTH)
//   READ_NUM_WIDTH : width of the read id carried with a drain
//   status_e       : pipeline slot status (BUBBLE, BCK_INI, BCK_RUN)
//   pack_entry     : packs the four 64-bit fields into one bank word
package smem_store_unit_pkg;

   localparam int SMEM_DEPTH     = 128;
   localparam int SMEM_ADDR_W    = 7;
   localparam int READ_NUM_WIDTH = 8;
   localparam int WORD_W         = 256;

   typedef enum logic [1:0] {
      BUBBLE  = 2'd0,
      BCK_INI = 2'd1,
      BCK_RUN = 2'd2
   } status_e;

   // x_0 occupies the most significant lane, x_info the least.
   function automatic logic [WORD_W-1:0] pack_entry(
      input logic [63:0] x_0,
      input logic [63:0] x_1,
      input logic [63:0] x_2,
      input logic [63:0] x_info
   );
      return {x_0, x_1, x_2, x_info};
   endfunction

endpackage

// File: rtl/smem_bank.sv
// rtl/smem_bank.sv - 1W1R 256-bit bank with registered read port
//   clk     : clock
//   rst     : async active-low reset (clears the read register only)
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write word
//   rd_en   : read strobe; rd_data holds when low
//   rd_addr : read address
//   rd_data : registered read word, old data on same-address write
module smem_bank
   import smem_store_unit_pkg::*;
#(
   parameter int DEPTH  = SMEM_DEPTH,
   parameter int ADDR_W = SMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] r_mem [0:DEPTH-1];
   logic [WORD_W-1:0] r_rd_data;

   // Storage has no reset; contents are undefined after reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Non-blocking read of the array gives read-before-write on a collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/smem_store_unit.sv
// rtl/smem_store_unit.sv - curr/mem entry store with read port and mem-bank drain stream
//   clk, rst                : clock, async active-low reset
//   stall                   : freezes the curr read-port output registers
//   store_valid_curr/curr_* : curr bank write
//   store_valid_mem/mem_*   : mem bank write
//   rd_en, rd_addr          : curr bank read request
//   rd_x0..rd_info,rd_valid : curr read data, one cycle after rd_en
//   drain_start/count/read_num : start draining mem entries 0..count-1
//   out_valid/out_ready/out_* : drained entry stream
//   drain_busy, drain_done  : drain status
//   wr_conflict             : sticky flag, mem write seen while draining
module smem_store_unit
   import smem_store_unit_pkg::*;
#(
   parameter int DEPTH  = SMEM_DEPTH,
   parameter int ADDR_W = SMEM_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      store_valid_curr,
   input  logic [63:0]               curr_x_0,
   input  logic [63:0]               curr_x_1,
   input  logic [63:0]               curr_x_2,
   input  logic [63:0]               curr_x_info,
   input  logic [ADDR_W-1:0]         curr_x_addr,
   input  logic                      store_valid_mem,
   input  logic [63:0]               mem_x_0,
   input  logic [63:0]               mem_x_1,
   input  logic [63:0]               mem_x_2,
   input  logic [63:0]               mem_x_info,
   input  logic [ADDR_W-1:0]         mem_x_addr,
   input  logic                      rd_en,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [63:0]               rd_x0,
   output logic [63:0]               rd_x1,
   output logic [63:0]               rd_x2,
   output logic [63:0]               rd_info,
   output logic                      rd_valid,
   input  logic                      drain_start,
   input  logic [ADDR_W-1:0]         drain_count,
   input  logic [READ_NUM_WIDTH-1:0] drain_read_num,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [63:0]               out_x0,
   output logic [63:0]               out_x1,
   output logic [63:0]               out_x2,
   output logic [63:0]               out_info,
   output logic [READ_NUM_WIDTH-1:0] out_read_num,
   output logic                      drain_busy,
   output logic                      drain_done,
   output logic                      wr_conflict
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [1:0]                r_state;
   logic [ADDR_W-1:0]         r_ptr;
   logic [ADDR_W-1:0]         r_count;
   logic                      r_out_valid;
   logic [READ_NUM_WIDTH-1:0] r_read_num;
   logic                      r_drain_done;
   logic                      r_wr_conflict;
   logic                      r_rd_valid;

   logic [WORD_W-1:0]         w_curr_rd_data;
   logic [WORD_W-1:0]         w_mem_rd_data;
   logic                      w_curr_rd_en;
   logic                      w_mem_rd_en;
   logic [ADDR_W-1:0]         w_mem_rd_addr;
   logic                      w_accept;
   logic                      w_last;

   // ---------------- curr bank and read port ----------------
   assign w_curr_rd_en = rd_en & ~stall;

   smem_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_curr_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (store_valid_curr),
      .wr_addr (curr_x_addr),
      .wr_data (pack_entry(curr_x_0, curr_x_1, curr_x_2, curr_x_info)),
      .rd_en   (w_curr_rd_en),
      .rd_addr (rd_addr),
      .rd_data (w_curr_rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_valid <= 1'b0;
      end else if (!stall) begin
         r_rd_valid <= rd_en;
      end
   end

   assign rd_x0    = w_curr_rd_data[255:192];
   assign rd_x1    = w_curr_rd_data[191:128];
   assign rd_x2    = w_curr_rd_data[127:64];
   assign rd_info  = w_curr_rd_data[63:0];
   assign rd_valid = r_rd_valid;

   // ---------------- mem bank and drain ----------------
   assign w_accept = r_out_valid & out_ready;
   assign w_last   = (r_ptr == (r_count - ADDR_ONE));

   // The bank read register is the out_* holding register: it is only
   // reloaded when a new entry must be presented, so out_* stays stable
   // across backpressure. Entry 0 is fetched on drain_start, entry k+1 on
   // acceptance of entry k.
   always_comb begin
      w_mem_rd_en   = 1'b0;
      w_mem_rd_addr = r_ptr + ADDR_ONE;
      if (r_state == ST_IDLE && drain_start && drain_count != '0) begin
         w_mem_rd_en   = 1'b1;
         w_mem_rd_addr = '0;
      end else if (r_state == ST_DRAIN && w_accept && !w_last) begin
         w_mem_rd_en   = 1'b1;
      end
   end

   smem_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (store_valid_mem),
      .wr_addr (mem_x_addr),
      .wr_data (pack_entry(mem_x_0, mem_x_1, mem_x_2, mem_x_info)),
      .rd_en   (w_mem_rd_en),
      .rd_addr (w_mem_rd_addr),
      .rd_data (w_mem_rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_count      <= '0;
         r_out_valid  <= 1'b0;
         r_read_num   <= '0;
         r_drain_done <= 1'b0;
      end else begin
         r_drain_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (drain_start) begin
                  if (drain_count == '0) begin
                     // Nothing to stream: report completion directly.
                     r_drain_done <= 1'b1;
                  end else begin
                     r_count     <= drain_count;
                     r_read_num  <= drain_read_num;
                     r_ptr       <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_out_valid  <= 1'b0;
                     r_drain_done <= 1'b1;
                     r_state      <= ST_FLUSH;
                  end else begin
                     r_ptr <= r_ptr + ADDR_ONE;
                  end
               end
            end
            ST_FLUSH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_conflict <= 1'b0;
      end else if (store_valid_mem && r_state != ST_IDLE) begin
         r_wr_conflict <= 1'b1;
      end
   end

   assign out_valid    = r_out_valid;
   assign out_x0       = w_mem_rd_data[255:192];
   assign out_x1       = w_mem_rd_data[191:128];
   assign out_x2       = w_mem_rd_data[127:64];
   assign out_info     = w_mem_rd_data[63:0];
   assign out_read_num = r_read_num;
   assign drain_busy   = (r_state != ST_IDLE);
   assign drain_done   = r_drain_done;
   assign wr_conflict  = r_wr_conflict;

endmodule

// File: doc/smem_store_unit.md
SMEM_STORE_UNIT -- requirements
Module: smem_store_unit

Interface
REQ-001 Parameter DEPTH, default 128, entries per bank.
REQ-002 Parameter ADDR_W, default 7, address width (= clog2(DEPTH)).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  pipeline stall; freezes read-port output registers.
REQ-006 store_valid_curr  input  1  write strobe, curr bank.
REQ-007 curr_x_0, curr_x_1, curr_x_2, curr_x_info  input  64 each  curr entry payload.
REQ-008 curr_x_addr  input  ADDR_W  curr write address.
REQ-009 store_valid_mem  input  1  write strobe, mem bank.
REQ-010 mem_x_0, mem_x_1, mem_x_2, mem_x_info  input  64 each  mem entry payload.
REQ-011 mem_x_addr  input  ADDR_W  mem write address.
REQ-012 rd_en  input  1  curr-bank read request.
REQ-013 rd_addr  input  ADDR_W  curr read address (current_rd_addr of the stage).
REQ-014 rd_x0, rd_x1, rd_x2, rd_info  output  64 each  curr read data.
REQ-015 rd_valid  output  1  read data valid.
REQ-016 drain_start  input  1  one-cycle pulse: begin draining the mem bank.
REQ-017 drain_count  input  ADDR_W  number of mem entries to drain (final mem_wr_addr).
REQ-018 drain_read_num  input  `READ_NUM_WIDTH  read id, latched with drain_start.
REQ-019 out_valid / out_ready  output / input  1  result stream handshake.
REQ-020 out_x0, out_x1, out_x2, out_info  output  64 each  drained mem entry.
REQ-021 out_read_num  output  `READ_NUM_WIDTH  latched read id.
REQ-022 drain_busy  output  1  high in DRAIN/FLUSH.
REQ-023 drain_done  output  1  one-cycle pulse on drain completion.
REQ-024 wr_conflict  output  1  sticky error: mem write while draining.

Function
REQ-025 Writes SHALL store {x_0,x_1,x_2,x_info} at the given address on the edge where the strobe is high; curr and mem writes in the same cycle SHALL both complete.
REQ-026 Read latency SHALL be 1 cycle: rd_en at cycle N -> rd_* and rd_valid=1 at N+1; rd_valid=0 the cycle after rd_en=0.
REQ-027 Same-cycle curr write and read to the same address SHALL return the old (pre-write) data.
REQ-028 While stall=1, rd_* and rd_valid SHALL hold their values; rd_en is ignored; writes still complete.
REQ-029 FSM states IDLE, DRAIN, FLUSH; reset state IDLE.
REQ-030 IDLE: drain_start with drain_count=0 -> drain_done pulses next cycle, stay IDLE; drain_count>0 -> latch count and read id, pointer=0, go DRAIN.
REQ-031 DRAIN: entry at pointer SHALL be presented on out_* with out_valid=1; pointer advances only on out_valid&&out_ready; out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-032 When the entry at pointer=count-1 is accepted, go FLUSH; FLUSH lasts one cycle, pulses drain_done, returns to IDLE.
REQ-033 drain_start outside IDLE SHALL be ignored.
REQ-034 A store_valid_mem in DRAIN or FLUSH SHALL still write and SHALL set wr_conflict, cleared only by reset.
REQ-035 Pointer arithmetic SHALL be ADDR_W bits; drain_count is unsigned, max DEPTH-1.

Reset
REQ-036 On rst=0: FSM IDLE, pointer 0, rd_* 0, rd_valid 0, out_* 0, out_valid 0, out_read_num 0, drain_busy 0, drain_done 0, wr_conflict 0; bank contents undefined.
REQ-037 Reset asserted mid-drain SHALL abort immediately with no drain_done pulse; out_valid low.

Structure
REQ-038 DEPTH, ADDR_W, `READ_NUM_WIDTH and the status codes (BUBBLE, BCK_INI, BCK_RUN) SHALL live in the shared pipeline header package.
REQ-039 One sub-module, smem_bank (1W1R, 256-bit word, registered read), SHALL be instantiated twice (curr, mem).

Verification
REQ-040 Write curr addr 5 = {1,2,3,4}; rd_en addr 5 next cycle -> rd_x0..info = 1,2,3,4, rd_valid=1 one cycle later.
REQ-041 Same-cycle curr write addr 9 = {A} (old {B}) and read addr 9 -> rd_x0 = B; next read -> A.
REQ-042 Fill mem 0..2, drain_start count=3, out_ready=1 -> 3 beats in address order, drain_done pulses once, drain_busy low afterwards.
REQ-043 Same drain with out_ready toggling 1,0,0,1,... -> out_* stable while stalled, exactly 3 accepted beats.
REQ-044 drain_start count=0 -> no out_valid, drain_done next cycle; mem write during a count=2 drain -> wr_conflict=1 until reset.
REQ-045 Assert rst=0 after first accepted beat of count=4 drain -> out_valid=0, FSM IDLE, no drain_done.
